// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg
//   Shared definitions for the SDRAM command-bus arbiter: bus type, the
//   NOP command encoding, the bus value driven while no sequencer owns
//   the bus, default timing parameters, the one-hot arbiter state type
//   and the IDLE-state grant priority function.
//   Bus layout: {cmd[3:0], cke, a[12:0], ba[1:0]} = 20 bits.
package sdram_arbiter_pkg;

  localparam int BUS_W = 20;
  typedef logic [BUS_W-1:0] cmd_bus_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;

  // NOP with clock enable high, address and bank zero
  localparam cmd_bus_t IDLE_BUS = {CMD_NOP, 1'b1, 13'd0, 2'd0};

  // 7.8 us at 100 MHz
  localparam int REF_CYC_DEF = 780;
  localparam int TIMEOUT_DEF = 63;

  typedef enum logic [4:0] {
    ST_INIT  = 5'b00001,
    ST_IDLE  = 5'b00010,
    ST_AREF  = 5'b00100,
    ST_WRITE = 5'b01000,
    ST_READ  = 5'b10000
  } state_t;

  // Refresh first; simultaneous write/read requests alternate on last_wr.
  function automatic state_t next_grant(input logic ref_pend,
                                        input logic wr_req,
                                        input logic rd_req,
                                        input logic last_wr);
    state_t s;
    if (ref_pend) begin
      s = ST_AREF;
    end else if (wr_req && rd_req) begin
      s = last_wr ? ST_READ : ST_WRITE;
    end else if (wr_req) begin
      s = ST_WRITE;
    end else if (rd_req) begin
      s = ST_READ;
    end else begin
      s = ST_IDLE;
    end
    return s;
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if
//   Bundles the arbiter's sequencer handshakes and the muxed command bus.
//   master : arbiter side (drives enables, sdram_bus and status flags)
//   slave  : environment side (init/refresh/write/read sequencers, front
//            ends and pad registers)
//   Signals: init_done/init_bus, aref_en/aref_done/aref_bus,
//            wr_req/wr_en/wr_done/wr_bus, rd_req/rd_en/rd_done/rd_bus,
//            sdram_bus, ref_miss, err_timeout.
interface sdram_arbiter_if;
  import sdram_arbiter_pkg::*;

  logic     init_done;
  cmd_bus_t init_bus;
  logic     aref_en;
  logic     aref_done;
  cmd_bus_t aref_bus;
  logic     wr_req;
  logic     wr_en;
  logic     wr_done;
  cmd_bus_t wr_bus;
  logic     rd_req;
  logic     rd_en;
  logic     rd_done;
  cmd_bus_t rd_bus;
  cmd_bus_t sdram_bus;
  logic     ref_miss;
  logic     err_timeout;

  modport master (
    input  init_done, init_bus,
    input  aref_done, aref_bus,
    input  wr_req, wr_done, wr_bus,
    input  rd_req, rd_done, rd_bus,
    output aref_en, wr_en, rd_en,
    output sdram_bus, ref_miss, err_timeout
  );

  modport slave (
    output init_done, init_bus,
    output aref_done, aref_bus,
    output wr_req, wr_done, wr_bus,
    output rd_req, rd_done, rd_bus,
    input  aref_en, wr_en, rd_en,
    input  sdram_bus, ref_miss, err_timeout
  );

endinterface

// File: rtl/sdram_arbiter_ref_timer.sv
// sdram_arbiter_ref_timer
//   Refresh period counter. Counts 0..REF_CYC-1 while run is high (held at
//   0 otherwise), raises ref_pend on each wrap and drops it on clr. A wrap
//   that finds an unserviced pending refresh sets the sticky ref_miss.
//   Ports: clk, rst (sync, active-high), run (arbiter out of INIT),
//          clr (refresh completed this cycle), ref_pend, ref_miss.
module sdram_arbiter_ref_timer #(
  parameter int REF_CYC = 780
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic ref_pend,
  output logic ref_miss
);

  localparam int TW = (REF_CYC > 1) ? $clog2(REF_CYC) : 1;

  logic [TW-1:0] tmr_r;
  logic          wrap_s;

  assign wrap_s = run && (tmr_r == TW'(REF_CYC - 1));

  // Period counter, pending-refresh flag and sticky miss flag
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_r    <= TW'(0);
      ref_pend <= 1'b0;
      ref_miss <= 1'b0;
    end else begin
      if (!run || wrap_s) begin
        tmr_r <= TW'(0);
      end else begin
        tmr_r <= tmr_r + TW'(1);
      end
      // A new request wins over a clear landing in the same cycle.
      if (wrap_s) begin
        ref_pend <= 1'b1;
      end else if (clr) begin
        ref_pend <= 1'b0;
      end
      // The old request being serviced this very cycle is not a miss.
      if (wrap_s && ref_pend && !clr) begin
        ref_miss <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Owns the 20-bit SDRAM command bus and grants it to one of four
//   sequencers (init, auto-refresh, write, read). A granted sequencer sees
//   a level enable until its one-cycle done pulse; the arbiter then spends
//   at least one IDLE cycle before the next grant. A grant that does not
//   finish within TIMEOUT cycles is aborted and flagged in err_timeout.
//   Ports: clk, rst (sync, active-high), arb (sdram_arbiter_if.master).
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int REF_CYC = REF_CYC_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  sdram_arbiter_if.master  arb
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n, cnt_inc_s;
  logic             last_wr_r, last_wr_n;
  logic             err_r, err_n;
  logic             aref_en_r, wr_en_r, rd_en_r;
  logic             granted_s, done_s;
  logic             ref_pend_s, ref_clr_s, run_s;
  cmd_bus_t         bus_s;

  assign run_s     = (state_r != ST_INIT);
  // Done pulses from sequencers that do not hold the grant are ignored.
  assign ref_clr_s = (state_r == ST_AREF) && arb.aref_done;

  sdram_arbiter_ref_timer #(.REF_CYC(REF_CYC)) u_ref_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (run_s),
    .clr      (ref_clr_s),
    .ref_pend (ref_pend_s),
    .ref_miss (arb.ref_miss)
  );

  // Next-state, bus mux and timeout counter
  always_comb begin
    state_n   = state_r;
    cnt_n     = CNT_W'(0);
    cnt_inc_s = cnt_r + CNT_W'(1);
    last_wr_n = last_wr_r;
    err_n     = err_r;
    granted_s = 1'b0;
    done_s    = 1'b0;
    bus_s     = IDLE_BUS;

    case (state_r)
      ST_INIT: begin
        bus_s = arb.init_bus;
        if (arb.init_done) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_INIT;
        end
      end
      ST_IDLE: begin
        bus_s   = IDLE_BUS;
        state_n = next_grant(ref_pend_s, arb.wr_req, arb.rd_req, last_wr_r);
      end
      ST_AREF: begin
        bus_s     = arb.aref_bus;
        granted_s = 1'b1;
        done_s    = arb.aref_done;
      end
      ST_WRITE: begin
        bus_s     = arb.wr_bus;
        granted_s = 1'b1;
        done_s    = arb.wr_done;
      end
      ST_READ: begin
        bus_s     = arb.rd_bus;
        granted_s = 1'b1;
        done_s    = arb.rd_done;
      end
      default: begin
        bus_s   = IDLE_BUS;
        state_n = ST_INIT;
      end
    endcase

    // Done beats a timeout landing on the same cycle; cnt_inc_s counts the
    // granted cycles including the current one.
    if (granted_s) begin
      if (done_s) begin
        state_n   = ST_IDLE;
        last_wr_n = (state_r == ST_WRITE);
      end else if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
        state_n = ST_IDLE;
        err_n   = 1'b1;
      end else begin
        state_n = state_r;
        cnt_n   = cnt_inc_s;
      end
    end else begin
      cnt_n = CNT_W'(0);
    end
  end

  // State register with registered enables decoded from the next state,
  // so an enable rises on the grant edge and falls on the done edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_INIT;
      cnt_r     <= CNT_W'(0);
      last_wr_r <= 1'b0;
      err_r     <= 1'b0;
      aref_en_r <= 1'b0;
      wr_en_r   <= 1'b0;
      rd_en_r   <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      last_wr_r <= last_wr_n;
      err_r     <= err_n;
      aref_en_r <= (state_n == ST_AREF);
      wr_en_r   <= (state_n == ST_WRITE);
      rd_en_r   <= (state_n == ST_READ);
    end
  end

  assign arb.aref_en     = aref_en_r;
  assign arb.wr_en       = wr_en_r;
  assign arb.rd_en       = rd_en_r;
  assign arb.err_timeout = err_r;
  assign arb.sdram_bus   = bus_s;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Directed bench for sdram_arbiter with REF_CYC=50, TIMEOUT=63. Simple
//   sequencer models return done a fixed number of cycles after their
//   enable rises (write 4, read 12, refresh 6; refresh can be made to hang).
module tb_sdram_arbiter;

  localparam int REF_CYC  = 50;
  localparam int TIMEOUT  = 63;
  localparam int WR_LAT   = 4;
  localparam int RD_LAT   = 12;
  localparam int AREF_LAT = 6;

  localparam logic [19:0] INIT_B = 20'hABCDE;
  localparam logic [19:0] AREF_B = 20'h11111;
  localparam logic [19:0] WR_B   = 20'h22222;
  localparam logic [19:0] RD_B   = 20'h33333;
  localparam logic [19:0] IDLE_B = 20'h78000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic aref_hang = 1'b0;
  logic mon_on = 1'b0;
  logic [7:0] wr_cnt = 8'd0;
  logic [7:0] rd_cnt = 8'd0;
  logic [7:0] aref_cnt = 8'd0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_arbiter_if arb_if ();

  sdram_arbiter #(.REF_CYC(REF_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb_if)
  );

  assign arb_if.init_bus  = INIT_B;
  assign arb_if.aref_bus  = AREF_B;
  assign arb_if.wr_bus    = WR_B;
  assign arb_if.rd_bus    = RD_B;
  assign arb_if.wr_done   = arb_if.wr_en && (wr_cnt == 8'(WR_LAT - 1));
  assign arb_if.rd_done   = arb_if.rd_en && (rd_cnt == 8'(RD_LAT - 1));
  assign arb_if.aref_done = arb_if.aref_en && !aref_hang && (aref_cnt == 8'(AREF_LAT - 1));

  // Sequencer models: count cycles with enable high
  always @(posedge clk) begin
    wr_cnt   <= arb_if.wr_en   ? wr_cnt + 8'd1   : 8'd0;
    rd_cnt   <= arb_if.rd_en   ? rd_cnt + 8'd1   : 8'd0;
    aref_cnt <= arb_if.aref_en ? aref_cnt + 8'd1 : 8'd0;
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check20(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Only one enable may be high in any cycle
  always @(negedge clk) begin
    if (mon_on) begin
      check1("onehot_en", ($countones({arb_if.aref_en, arb_if.wr_en, arb_if.rd_en}) <= 1), 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic en_of(input int sel);
    case (sel)
      0:       return arb_if.aref_en;
      1:       return arb_if.wr_en;
      default: return arb_if.rd_en;
    endcase
  endfunction

  // Leaves the arbiter in its first IDLE cycle (refresh timer = 0).
  task automatic reset_init();
    rst = 1'b1;
    arb_if.init_done = 1'b0;
    arb_if.wr_req = 1'b0;
    arb_if.rd_req = 1'b0;
    tick();
    rst = 1'b0;
    arb_if.init_done = 1'b1;
    tick();
  endtask

  task automatic count_high(input int sel, input logic [19:0] exp_bus, input int limit,
                            output int n, output logic bus_ok);
    n = 0;
    bus_ok = 1'b1;
    while (en_of(sel) && n < limit) begin
      if (arb_if.sdram_bus !== exp_bus) bus_ok = 1'b0;
      n++;
      tick();
    end
  endtask

  task automatic wait_rise(input int sel, input int limit, output int n);
    n = 0;
    while (!en_of(sel) && n < limit) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic        init_done;
    logic        wr_req;
    logic        rd_req;
    logic [19:0] exp_bus;
    logic [2:0]  exp_en;   // {aref, wr, rd}
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n;
    logic ok;
    int g;
    int seq[4];
    logic prev_wr, prev_rd;

    vecs[0] = '{1'b1, 1'b0, 1'b0, IDLE_B, 3'b000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, IDLE_B, 3'b000};
    vecs[2] = '{1'b1, 1'b1, 1'b0, WR_B,   3'b010};
    vecs[3] = '{1'b1, 1'b0, 1'b0, WR_B,   3'b010};
    vecs[4] = '{1'b1, 1'b0, 1'b0, WR_B,   3'b010};
    vecs[5] = '{1'b1, 1'b0, 1'b0, WR_B,   3'b010};
    vecs[6] = '{1'b1, 1'b0, 1'b0, IDLE_B, 3'b000};
    vecs[7] = '{1'b1, 1'b0, 1'b1, RD_B,   3'b001};
    vecs[8] = '{1'b1, 1'b0, 1'b1, RD_B,   3'b001};

    // Test 1: reset and init phase
    arb_if.init_done = 1'b0;
    arb_if.wr_req = 1'b0;
    arb_if.rd_req = 1'b0;
    rst = 1'b1;
    tick();
    mon_on = 1'b1;
    check20("rst_bus", arb_if.sdram_bus, INIT_B);
    check20("rst_en", {17'd0, arb_if.aref_en, arb_if.wr_en, arb_if.rd_en}, 20'd0);
    check1("rst_err_timeout", arb_if.err_timeout, 1'b0);
    check1("rst_ref_miss", arb_if.ref_miss, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check20("init_bus", arb_if.sdram_bus, INIT_B);
      check20("init_en", {17'd0, arb_if.aref_en, arb_if.wr_en, arb_if.rd_en}, 20'd0);
    end
    for (int i = 0; i < 9; i++) begin
      arb_if.init_done = vecs[i].init_done;
      arb_if.wr_req    = vecs[i].wr_req;
      arb_if.rd_req    = vecs[i].rd_req;
      tick();
      check20("vec_bus", arb_if.sdram_bus, vecs[i].exp_bus);
      check20("vec_en", {17'd0, arb_if.aref_en, arb_if.wr_en, arb_if.rd_en},
              {17'd0, vecs[i].exp_en});
    end

    // Test 2: read only, 12-cycle grant, one idle cycle, regrant
    reset_init();
    arb_if.rd_req = 1'b1;
    tick();
    check1("t2_rd_grant", arb_if.rd_en, 1'b1);
    count_high(2, RD_B, 40, n, ok);
    check_int("t2_rd_en_cycles", n, RD_LAT);
    check1("t2_bus_is_rd", ok, 1'b1);
    check20("t2_idle_bus", arb_if.sdram_bus, IDLE_B);
    tick();
    check1("t2_regrant", arb_if.rd_en, 1'b1);

    // Test 3: both requests held -> W,R,W,R
    reset_init();
    arb_if.wr_req = 1'b1;
    arb_if.rd_req = 1'b1;
    g = 0;
    prev_wr = 1'b0;
    prev_rd = 1'b0;
    for (int c = 0; c < 200 && g < 4; c++) begin
      tick();
      if (arb_if.wr_en && !prev_wr) begin seq[g] = 1; g++; end
      else if (arb_if.rd_en && !prev_rd) begin seq[g] = 2; g++; end
      prev_wr = arb_if.wr_en;
      prev_rd = arb_if.rd_en;
    end
    check_int("t3_grant_count", g, 4);
    for (int i = 0; i < 4 && i < g; i++) begin
      check_int("t3_grant_order", seq[i], (i % 2 == 0) ? 1 : 2);
    end
    arb_if.wr_req = 1'b0;
    arb_if.rd_req = 1'b0;

    // Test 4: refresh falls due mid-read, serviced after the read
    reset_init();
    repeat (40) tick();
    arb_if.rd_req = 1'b1;
    tick();
    check1("t4_rd_grant", arb_if.rd_en, 1'b1);
    arb_if.rd_req = 1'b0;
    count_high(2, RD_B, 40, n, ok);
    check_int("t4_rd_not_preempted", n, RD_LAT);
    check1("t4_idle_dwell", arb_if.aref_en, 1'b0);
    check20("t4_idle_bus", arb_if.sdram_bus, IDLE_B);
    tick();
    check1("t4_aref_grant", arb_if.aref_en, 1'b1);
    check20("t4_aref_bus", arb_if.sdram_bus, AREF_B);
    count_high(0, AREF_B, 40, n, ok);
    check_int("t4_aref_cycles", n, AREF_LAT);
    check1("t4_ref_miss", arb_if.ref_miss, 1'b0);
    check1("t4_err_timeout", arb_if.err_timeout, 1'b0);
    tick();
    check1("t4_pend_cleared", arb_if.aref_en, 1'b0);

    // Test 5: refresh never completes -> timeout, miss, retry
    reset_init();
    aref_hang = 1'b1;
    wait_rise(0, 80, n);
    check1("t5_aref_grant", arb_if.aref_en, 1'b1);
    check_int("t5_first_ref_cycle", n, REF_CYC + 1);
    check1("t5_miss_before", arb_if.ref_miss, 1'b0);
    check1("t5_err_before", arb_if.err_timeout, 1'b0);
    count_high(0, AREF_B, 200, n, ok);
    check_int("t5_timeout_cycles", n, TIMEOUT);
    check1("t5_err_timeout", arb_if.err_timeout, 1'b1);
    check1("t5_ref_miss", arb_if.ref_miss, 1'b1);
    aref_hang = 1'b0;
    tick();
    check1("t5_aref_regrant", arb_if.aref_en, 1'b1);

    // Test 6: reset in the middle of a write
    arb_if.wr_req = 1'b1;
    count_high(0, AREF_B, 20, n, ok);
    check_int("t6_aref_retry_cycles", n, AREF_LAT);
    wait_rise(1, 20, n);
    check1("t6_wr_grant", arb_if.wr_en, 1'b1);
    check1("t6_err_sticky", arb_if.err_timeout, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    check1("t6_wr_en_cleared", arb_if.wr_en, 1'b0);
    check20("t6_bus_init", arb_if.sdram_bus, INIT_B);
    check1("t6_err_cleared", arb_if.err_timeout, 1'b0);
    check1("t6_miss_cleared", arb_if.ref_miss, 1'b0);
    rst = 1'b0;
    arb_if.wr_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
